ctrl_sequencer: RTL and testbench

- Fetch/decode/execute sequencer for the EV22G5 core.
- Fetches 24-bit instructions from program memory over a req/ack handshake, holds them in IR, and strobes the microinstruction decoder and the datapath.
- Owns PC and resolves group-1 flow control (JMP/JZE/JNE/JCY/RET/BSR) using ALU flags and an internal return stack.

---
 rtl/ctrl_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for the EV22G5 core: fetches 24-bit words over
// a req/ack handshake, strobes decoder and datapath, and resolves group-1 flow control.
module ctrl_sequencer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned STK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              pm_req,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic              pm_ack,
  input  logic [23:0]       pm_data,
  output logic [23:0]       ir,
  output logic              mir_load,
  output logic              exec_en,
  input  logic              flag_z,
  input  logic              flag_cy,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_err,
  output logic              busy
);

  localparam int unsigned IW       = 24;
  localparam int unsigned SP_IDX_W = $clog2(STK_DEPTH);
  localparam int unsigned SP_W     = SP_IDX_W + 1;

  localparam logic [7:0] OP_JMP = 8'd0;
  localparam logic [7:0] OP_JZE = 8'd1;
  localparam logic [7:0] OP_JNE = 8'd2;
  localparam logic [7:0] OP_JCY = 8'd3;
  localparam logic [7:0] OP_RET = 8'd4;
  localparam logic [7:0] OP_BSR = 8'd5;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                stk_err_q, stk_err_d;
  logic                pm_req_q, pm_req_d;
  logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
  logic                mir_load_q, mir_load_d;
  logic                exec_en_q, exec_en_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   stk_q [STK_DEPTH];
  logic                push_c;
  logic [ADDR_W-1:0]   push_data_c;
  logic [SP_IDX_W-1:0] top_idx_c;
  logic [ADDR_W-1:0]   pc_inc_c;
  logic [ADDR_W-1:0]   target_c;
  logic [7:0]          op_c;
  logic [3:0]          grp_c;

  assign pc_inc_c  = pc_q + ADDR_W'(1);
  assign target_c  = ir_q[ADDR_W-1:0];
  assign op_c      = ir_q[19:12];
  assign grp_c     = ir_q[23:20];
  assign top_idx_c = SP_IDX_W'(sp_q - SP_W'(1));

  // Next-state, PC resolution and registered-output precompute
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    sp_d        = sp_q;
    stk_err_d   = stk_err_q;
    push_c      = 1'b0;
    push_data_c = pc_inc_c;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (pm_ack && pm_req_q) begin
          ir_d    = pm_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        pc_d    = pc_inc_c;
        if (grp_c == 4'h1) begin
          case (op_c)
            OP_JMP: pc_d = target_c;
            OP_JZE: if (flag_z)  pc_d = target_c;
            OP_JNE: if (!flag_z) pc_d = target_c;
            OP_JCY: if (flag_cy) pc_d = target_c;
            OP_RET: begin
              if (sp_q != '0) begin
                pc_d = stk_q[top_idx_c];
                sp_d = sp_q - SP_W'(1);
              end else begin
                stk_err_d = 1'b1;
              end
            end
            OP_BSR: begin
              if (sp_q != SP_W'(STK_DEPTH)) begin
                push_c = 1'b1;
                pc_d   = target_c;
                sp_d   = sp_q + SP_W'(1);
              end else begin
                stk_err_d = 1'b1;
              end
            end
            default: pc_d = pc_inc_c;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    pm_req_d   = (state_d == S_FETCH);
    pm_addr_d  = (state_d == S_FETCH) ? pc_d : pm_addr_q;
    mir_load_d = (state_d == S_DECODE);
    exec_en_d  = (state_d == S_EXEC);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      sp_q       <= '0;
      stk_err_q  <= 1'b0;
      pm_req_q   <= 1'b0;
      pm_addr_q  <= '0;
      mir_load_q <= 1'b0;
      exec_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      sp_q       <= sp_d;
      stk_err_q  <= stk_err_d;
      pm_req_q   <= pm_req_d;
      pm_addr_q  <= pm_addr_d;
      mir_load_q <= mir_load_d;
      exec_en_q  <= exec_en_d;
      busy_q     <= busy_d;
    end
  end

  // Return stack storage; sp_q indexes the next free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
    end else if (push_c) begin
      stk_q[sp_q[SP_IDX_W-1:0]] <= push_data_c;
    end
  end

  assign pm_req   = pm_req_q;
  assign pm_addr  = pm_addr_q;
  assign ir       = ir_q;
  assign mir_load = mir_load_q;
  assign exec_en  = exec_en_q;
  assign pc       = pc_q;
  assign stk_err  = stk_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed flow-control cases plus random instruction
// streams checked against a queue-based architectural model of PC and return stack.
module tb_ctrl_sequencer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              pm_req;
  logic [ADDR_W-1:0] pm_addr;
  logic              pm_ack;
  logic [23:0]       pm_data;
  logic [23:0]       ir;
  logic              mir_load;
  logic              exec_en;
  logic              flag_z;
  logic              flag_cy;
  logic [ADDR_W-1:0] pc;
  logic              stk_err;
  logic              busy;

  ctrl_sequencer #(.ADDR_W(ADDR_W), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pm_req(pm_req), .pm_addr(pm_addr),
    .pm_ack(pm_ack), .pm_data(pm_data), .ir(ir), .mir_load(mir_load),
    .exec_en(exec_en), .flag_z(flag_z), .flag_cy(flag_cy), .pc(pc),
    .stk_err(stk_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model state
  int m_pc;
  int m_stk[$];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input int op, input int x);
    return {4'h1, 8'(op), 12'(x)};
  endfunction

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  // Next PC from the instruction semantics, independent of any state machine
  function automatic void model_exec(input logic [23:0] w, input bit fz, input bit fcy);
    int inc = (m_pc + 1) % AMOD;
    int x   = int'(w[11:0]);
    int npc = inc;
    if (w[23:20] == 4'h1) begin
      case (int'(w[19:12]))
        0: npc = x;
        1: npc = fz  ? x : inc;
        2: npc = !fz ? x : inc;
        3: npc = fcy ? x : inc;
        4: if (m_stk.size() > 0) npc = m_stk.pop_back(); else m_err = 1'b1;
        5: if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); npc = x; end
           else m_err = 1'b1;
        default: npc = inc;
      endcase
    end
    m_pc = npc;
  endfunction

  // One full instruction; called and returns on a falling edge
  task automatic do_instr(input logic [23:0] w, input int dly, input bit fz,
                          input bit fcy, input bit keep_run);
    int n = 0;
    logic [23:0] ir_before;
    run = 1'b1;
    while (!pm_req && n < 10) begin @(negedge clk); n++; end
    check("fetch_req", 32'(pm_req), 32'd1);
    check("fetch_addr", 32'(pm_addr), 32'(m_pc));
    check("busy_fetch", 32'(busy), 32'd1);
    ir_before = ir;
    pm_ack = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("req_hold", 32'(pm_req), 32'd1);
      check("addr_hold", 32'(pm_addr), 32'(m_pc));
      check("ir_hold", 32'(ir), 32'(ir_before));
    end
    pm_ack  = 1'b1;
    pm_data = w;
    @(negedge clk);
    pm_ack  = 1'b0;
    pm_data = 24'($urandom);
    check("dec_mir", 32'(mir_load), 32'd1);
    check("dec_exec", 32'(exec_en), 32'd0);
    check("dec_req", 32'(pm_req), 32'd0);
    check("dec_ir", 32'(ir), 32'(w));
    run     = keep_run;
    flag_z  = fz;
    flag_cy = fcy;
    @(negedge clk);
    check("exe_en", 32'(exec_en), 32'd1);
    check("exe_mir", 32'(mir_load), 32'd0);
    model_exec(w, fz, fcy);
    @(negedge clk);
    check("pc", 32'(pc), 32'(m_pc));
    check("stk_err", 32'(stk_err), 32'(m_err));
    check("exe_pulse_end", 32'(exec_en), 32'd0);
    if (keep_run) begin
      check("next_req", 32'(pm_req), 32'd1);
      check("next_addr", 32'(pm_addr), 32'(m_pc));
    end else begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_req", 32'(pm_req), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(pm_req), 32'd0);
    check({tag, "_addr"}, 32'(pm_addr), 32'd0);
    check({tag, "_ir"}, 32'(ir), 32'd0);
    check({tag, "_mir"}, 32'(mir_load), 32'd0);
    check({tag, "_exec"}, 32'(exec_en), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_err"}, 32'(stk_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    int          sel;
    rst_n = 1'b0; run = 1'b0; pm_ack = 1'b0; pm_data = '0;
    flag_z = 1'b0; flag_cy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Straight-line zero words, then one slow ack at address 5
    for (int i = 0; i < 5; i++) do_instr(24'h000000, 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h000000, 4, 1'b0, 1'b0, 1'b1);

    // Conditional branches
    do_instr(24'h101020, 0, 1'b1, 1'b0, 1'b1);
    do_instr(24'h101020, 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h102020, 0, 1'b0, 1'b1, 1'b1);
    do_instr(24'h102020, 1, 1'b1, 1'b0, 1'b1);
    do_instr(24'h103040, 0, 1'b0, 1'b1, 1'b1);
    do_instr(24'h103040, 2, 1'b1, 1'b0, 1'b1);
    do_instr(mk(6, 12'h7AB), 0, 1'b1, 1'b1, 1'b1);

    // Subroutine call and return, then stack overflow
    do_instr(mk(0, 12'h010), 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h105100, 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h104000, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) do_instr(24'h105200, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) do_instr(24'h104000, 0, 1'b0, 1'b0, 1'b1);

    // PC wrap and wrapped return address
    do_instr(mk(0, 12'hFFF), 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h000000, 0, 1'b0, 1'b0, 1'b1);
    do_instr(mk(0, 12'hFFF), 0, 1'b0, 1'b0, 1'b1);
    do_instr(mk(5, 12'h123), 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h104000, 0, 1'b0, 1'b0, 1'b1);

    // Drop run in DECODE; stray ack while idle must be ignored
    do_instr(24'h300000, 0, 1'b0, 1'b0, 1'b0);
    w = ir;
    pm_ack = 1'b1; pm_data = 24'hABCDEF;
    repeat (2) @(negedge clk);
    pm_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_ir", 32'(ir), 32'(w));
    check("idle_ack_pc", 32'(pc), 32'(m_pc));

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) w = mk(int'($urandom_range(0, 9)), int'($urandom_range(0, AMOD - 1)));
      else         w = 24'($urandom);
      do_instr(w, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) != 0));
    end

    // Asynchronous reset in the middle of a fetch
    run = 1'b1;
    for (int n = 0; n < 10 && !pm_req; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Return on empty stack
    do_instr(24'h104000, 0, 1'b0, 1'b0, 1'b1);
    do_instr(24'h000000, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
